// File: rtl/seg_pkg.sv
// Shared types and constants for the Segway command authoriser.
//   auth_state_t : power-authorisation FSM states
//   rx_state_t   : serial receiver states
//   CMD_GO/STOP  : command bytes recognised by the auth FSM
package seg_pkg;

  typedef enum logic [1:0] {
    OFF,
    PWR1,
    PWR2
  } auth_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT
  } rx_state_t;

  localparam logic [7:0] CMD_GO   = 8'h47;
  localparam logic [7:0] CMD_STOP = 8'h53;

endpackage

// File: rtl/uart_rx.sv
// 8N1 serial receiver, LSB first.
//   clk, rst : system clock, async active-high reset
//   RX       : raw asynchronous serial line (idle high)
//   rx_data  : last byte received with a good stop bit
//   rx_rdy   : one-cycle pulse when rx_data updates
//   frm_err  : one-cycle pulse when a byte is dropped for a bad stop bit
module uart_rx
  import seg_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       frm_err
);

  localparam logic [15:0] HalfLast = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] FullLast = 16'(BAUD_DIV - 1);

  logic        r_rx_s1, r_rx_s2;
  rx_state_t   r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_rdy, r_ferr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_rdy   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_rx_s1 <= RX;
      r_rx_s2 <= r_rx_s1;
      r_rdy   <= 1'b0;
      r_ferr  <= 1'b0;
      unique case (r_state)
        RX_IDLE: begin
          // One cycle has already elapsed since the synchronised edge.
          if (!r_rx_s2) begin
            r_state <= RX_START;
            r_cnt   <= 16'd1;
          end
        end
        RX_START: begin
          if (r_cnt == HalfLast) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (r_cnt == FullLast) begin
            r_cnt   <= '0;
            r_shift <= {r_rx_s2, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= RX_STOP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (r_cnt == FullLast) begin
            r_cnt <= '0;
            if (r_rx_s2) begin
              r_data  <= r_shift;
              r_rdy   <= 1'b1;
              r_state <= RX_IDLE;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= RX_WAIT;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        RX_WAIT: begin
          // Line must return high before a new start edge is trusted.
          if (r_rx_s2) r_state <= RX_IDLE;
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign rx_data = r_data;
  assign rx_rdy  = r_rdy;
  assign frm_err = r_ferr;

endmodule

// File: rtl/cmd_auth.sv
// Power authorisation for the Segway platform from Bluetooth serial commands.
//   clk, rst  : system clock, async active-high reset
//   RX        : serial command input (8N1)
//   rider_off : rider-absent status from the steering block
//   pwr_up    : registered platform enable
//   rx_data   : last good received byte
//   rx_rdy    : one-cycle pulse per good byte
//   frm_err   : one-cycle pulse per byte dropped for a bad stop bit
module cmd_auth
  import seg_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 5208,
  parameter int unsigned LINK_TO  = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       rider_off,
  output logic       pwr_up,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       frm_err
);

  localparam bit          ToEn   = (LINK_TO != 0);
  localparam logic [24:0] ToLast = 25'(LINK_TO - 32'd1);

  auth_state_t r_state;
  logic        r_pwr_up;
  logic [24:0] r_to_cnt;
  logic        w_is_go, w_is_stop, w_expired;

  uart_rx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart_rx (
    .clk    (clk),
    .rst    (rst),
    .RX     (RX),
    .rx_data(rx_data),
    .rx_rdy (rx_rdy),
    .frm_err(frm_err)
  );

  assign w_is_go   = rx_rdy && (rx_data == CMD_GO);
  assign w_is_stop = rx_rdy && (rx_data == CMD_STOP);
  assign w_expired = ToEn && (r_to_cnt == ToLast);

  // Link watchdog: only runs while powered in PWR1, any received byte restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (r_state != PWR1 || rx_rdy) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != '1) begin
      r_to_cnt <= r_to_cnt + 25'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= OFF;
      r_pwr_up <= 1'b0;
    end else begin
      unique case (r_state)
        OFF: begin
          if (w_is_go) begin
            r_state  <= PWR1;
            r_pwr_up <= 1'b1;
          end
        end
        PWR1: begin
          // A lost link behaves exactly like a received stop command.
          if (!w_is_go && (w_is_stop || (!rx_rdy && w_expired))) begin
            if (rider_off) begin
              r_state  <= OFF;
              r_pwr_up <= 1'b0;
            end else begin
              r_state <= PWR2;
            end
          end
        end
        PWR2: begin
          // A fresh 'G' takes priority over the rider leaving.
          if (w_is_go) begin
            r_state <= PWR1;
          end else if (rider_off) begin
            r_state  <= OFF;
            r_pwr_up <= 1'b0;
          end
        end
        default: begin
          r_state  <= OFF;
          r_pwr_up <= 1'b0;
        end
      endcase
    end
  end

  assign pwr_up = r_pwr_up;

endmodule

// File: tb/tb_cmd_auth.sv
module tb_cmd_auth;

  localparam int BD  = 32;
  localparam int LTO = 4000;
  localparam int RDY_LAT = 2 + BD / 2 + 9 * BD;  // raw start edge to rx_rdy

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       RX = 1'b1;
  logic       rider_off = 1'b0;
  logic       pwr_up;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       frm_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int         rdy_cnt = 0, ferr_cnt = 0, both_cnt = 0;
  int         last_rdy_cyc = 0, last_tx_start = 0;
  logic [7:0] last_rdy_data = 8'h00;
  logic       pwr_at_rdy = 1'b0, pwr_after_rdy = 1'b0, prev_rdy = 1'b0;
  int         rdy_q[$];

  cmd_auth #(
    .BAUD_DIV(BD),
    .LINK_TO (LTO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .RX       (RX),
    .rider_off(rider_off),
    .pwr_up   (pwr_up),
    .rx_data  (rx_data),
    .rx_rdy   (rx_rdy),
    .frm_err  (frm_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (prev_rdy) pwr_after_rdy = pwr_up;
    if (rx_rdy === 1'b1) begin
      rdy_cnt++;
      last_rdy_data = rx_data;
      last_rdy_cyc  = cyc;
      pwr_at_rdy    = pwr_up;
      rdy_q.push_back(cyc);
    end
    if (frm_err === 1'b1) ferr_cnt++;
    if (rx_rdy === 1'b1 && frm_err === 1'b1) both_cnt++;
    prev_rdy = rx_rdy;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) wait_cyc(1);
  endtask

  // Called at posedge+1; returns at posedge+1 right after the stop bit.
  task automatic send_byte(input logic [7:0] d, input logic stop);
    last_tx_start = cyc;
    RX = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_cyc(BD);
      RX = d[i];
    end
    wait_cyc(BD);
    RX = stop;
    wait_cyc(BD);
    RX = 1'b1;
  endtask

  task automatic test_reset;
    wait_cyc(3);
    checks++; if (pwr_up !== 1'b0) begin failures++; $display("FAIL rst_pwr_up got=%b exp=0", pwr_up); end
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL rst_rx_data got=%h exp=00", rx_data); end
    checks++; if (rx_rdy !== 1'b0) begin failures++; $display("FAIL rst_rx_rdy got=%b exp=0", rx_rdy); end
    checks++; if (frm_err !== 1'b0) begin failures++; $display("FAIL rst_frm_err got=%b exp=0", frm_err); end
    rst = 1'b0;
    wait_cyc(5);
  endtask

  task automatic test_power_stop;
    int n0;
    n0 = rdy_cnt;
    rider_off = 1'b0;
    send_byte(8'h47, 1'b1);
    wait_cyc(2);
    checks++; if (rdy_cnt != n0 + 1) begin failures++; $display("FAIL t1_rdy_count got=%0d exp=%0d", rdy_cnt, n0 + 1); end
    checks++; if (last_rdy_data !== 8'h47) begin failures++; $display("FAIL t1_rx_data got=%h exp=47", last_rdy_data); end
    checks++; if (last_rdy_cyc - last_tx_start != RDY_LAT) begin failures++; $display("FAIL t1_rdy_latency got=%0d exp=%0d", last_rdy_cyc - last_tx_start, RDY_LAT); end
    checks++; if (pwr_at_rdy !== 1'b0) begin failures++; $display("FAIL t1_pwr_at_rdy got=%b exp=0", pwr_at_rdy); end
    checks++; if (pwr_after_rdy !== 1'b1) begin failures++; $display("FAIL t1_pwr_after_rdy got=%b exp=1", pwr_after_rdy); end
    send_byte(8'h53, 1'b1);
    wait_cyc(2);
    checks++; if (pwr_up !== 1'b1) begin failures++; $display("FAIL t1_pwr2_pwr_up got=%b exp=1", pwr_up); end
    rider_off = 1'b1;
    checks++; if (pwr_up !== 1'b1) begin failures++; $display("FAIL t1_pre_rider_off got=%b exp=1", pwr_up); end
    wait_cyc(1);
    checks++; if (pwr_up !== 1'b0) begin failures++; $display("FAIL t1_rider_off got=%b exp=0", pwr_up); end
    rider_off = 1'b0;
    wait_cyc(10);
  endtask

  task automatic test_stop_rider_off;
    send_byte(8'h47, 1'b1);
    rider_off = 1'b1;
    wait_cyc(50);
    checks++; if (pwr_up !== 1'b1) begin failures++; $display("FAIL t2_pwr1_ignores_rider got=%b exp=1", pwr_up); end
    send_byte(8'h53, 1'b1);
    wait_cyc(2);
    checks++; if (pwr_at_rdy !== 1'b1) begin failures++; $display("FAIL t2_pwr_at_rdy got=%b exp=1", pwr_at_rdy); end
    checks++; if (pwr_after_rdy !== 1'b0) begin failures++; $display("FAIL t2_pwr_after_rdy got=%b exp=0", pwr_after_rdy); end
    rider_off = 1'b0;
    wait_cyc(10);
  endtask

  task automatic test_foreign_framing;
    int n0, f0;
    n0 = rdy_cnt;
    send_byte(8'h41, 1'b1);
    wait_cyc(2);
    checks++; if (last_rdy_data !== 8'h41) begin failures++; $display("FAIL t3_data_41 got=%h exp=41", last_rdy_data); end
    checks++; if (last_rdy_cyc - last_tx_start != RDY_LAT) begin failures++; $display("FAIL t3_latency_41 got=%0d exp=%0d", last_rdy_cyc - last_tx_start, RDY_LAT); end
    send_byte(8'hFF, 1'b1);
    wait_cyc(2);
    checks++; if (rx_data !== 8'hFF) begin failures++; $display("FAIL t3_data_ff got=%h exp=ff", rx_data); end
    checks++; if (rdy_cnt != n0 + 2) begin failures++; $display("FAIL t3_rdy_count got=%0d exp=%0d", rdy_cnt, n0 + 2); end
    checks++; if (pwr_up !== 1'b0) begin failures++; $display("FAIL t3_foreign_pwr got=%b exp=0", pwr_up); end
    n0 = rdy_cnt;
    f0 = ferr_cnt;
    send_byte(8'h55, 1'b0);
    wait_cyc(BD);
    checks++; if (ferr_cnt != f0 + 1) begin failures++; $display("FAIL t3_frm_err_count got=%0d exp=%0d", ferr_cnt, f0 + 1); end
    checks++; if (rdy_cnt != n0) begin failures++; $display("FAIL t3_ferr_no_rdy got=%0d exp=%0d", rdy_cnt, n0); end
    checks++; if (rx_data !== 8'hFF) begin failures++; $display("FAIL t3_ferr_data_kept got=%h exp=ff", rx_data); end
    // Short start glitch must be rejected silently.
    RX = 1'b0;
    wait_cyc(10);
    RX = 1'b1;
    wait_cyc(3 * BD);
    checks++; if (rdy_cnt != n0 || ferr_cnt != f0 + 1) begin failures++; $display("FAIL t3_glitch got=rdy%0d/ferr%0d exp=rdy%0d/ferr%0d", rdy_cnt, ferr_cnt, n0, f0 + 1); end
    send_byte(8'h41, 1'b1);
    wait_cyc(2);
    checks++; if (rdy_cnt != n0 + 1 || rx_data !== 8'h41) begin failures++; $display("FAIL t3_recover got=%0d/%h exp=%0d/41", rdy_cnt, rx_data, n0 + 1); end
  endtask

  task automatic test_link_timeout;
    int c0;
    rider_off = 1'b0;
    c0 = cyc;
    send_byte(8'h47, 1'b1);
    wait_until(c0 + 2000);
    rider_off = 1'b1;
    wait_cyc(1);
    rider_off = 1'b0;
    checks++; if (pwr_up !== 1'b1) begin failures++; $display("FAIL t4_early_pwr1 got=%b exp=1", pwr_up); end
    wait_until(c0 + RDY_LAT + LTO - 6);
    rider_off = 1'b1;
    wait_cyc(1);
    rider_off = 1'b0;
    checks++; if (pwr_up !== 1'b1) begin failures++; $display("FAIL t4_before_expiry got=%b exp=1", pwr_up); end
    wait_until(c0 + RDY_LAT + LTO + 14);
    checks++; if (pwr_up !== 1'b1) begin failures++; $display("FAIL t4_pwr2_on got=%b exp=1", pwr_up); end
    rider_off = 1'b1;
    wait_cyc(1);
    checks++; if (pwr_up !== 1'b0) begin failures++; $display("FAIL t4_pwr2_rider_off got=%b exp=0", pwr_up); end
    rider_off = 1'b0;
    wait_cyc(10);
    // Keep-alive: 'G' every 3000 cycles holds PWR1 across several timeout periods.
    for (int k = 0; k < 4; k++) begin
      c0 = cyc;
      send_byte(8'h47, 1'b1);
      if (k < 3) wait_until(c0 + 3000);
    end
    wait_until(c0 + 3300);
    rider_off = 1'b1;
    wait_cyc(1);
    checks++; if (pwr_up !== 1'b1) begin failures++; $display("FAIL t4_keepalive got=%b exp=1", pwr_up); end
    send_byte(8'h53, 1'b1);
    wait_cyc(2);
    checks++; if (pwr_up !== 1'b0) begin failures++; $display("FAIL t4_cleanup got=%b exp=0", pwr_up); end
    rider_off = 1'b0;
    wait_cyc(10);
  endtask

  task automatic test_back_to_back;
    rdy_q.delete();
    rider_off = 1'b0;
    send_byte(8'h47, 1'b1);
    send_byte(8'h53, 1'b1);
    send_byte(8'h47, 1'b1);
    wait_cyc(5);
    checks++; if (rdy_q.size() != 3) begin failures++; $display("FAIL t5_pulses got=%0d exp=3", rdy_q.size()); end
    else begin
      checks++; if (rdy_q[1] - rdy_q[0] != 10 * BD) begin failures++; $display("FAIL t5_gap01 got=%0d exp=%0d", rdy_q[1] - rdy_q[0], 10 * BD); end
      checks++; if (rdy_q[2] - rdy_q[1] != 10 * BD) begin failures++; $display("FAIL t5_gap12 got=%0d exp=%0d", rdy_q[2] - rdy_q[1], 10 * BD); end
    end
    rider_off = 1'b1;
    wait_cyc(1);
    checks++; if (pwr_up !== 1'b1) begin failures++; $display("FAIL t5_final_pwr1 got=%b exp=1", pwr_up); end
    send_byte(8'h53, 1'b1);
    wait_cyc(2);
    rider_off = 1'b0;
    checks++; if (pwr_up !== 1'b0) begin failures++; $display("FAIL t5_cleanup got=%b exp=0", pwr_up); end
    wait_cyc(10);
  endtask

  task automatic test_reset_midframe;
    int n0;
    logic [7:0] d;
    d = 8'h47;
    send_byte(d, 1'b1);
    wait_cyc(5);
    checks++; if (pwr_up !== 1'b1 || rx_data !== 8'h47) begin failures++; $display("FAIL t6_setup got=%b/%h exp=1/47", pwr_up, rx_data); end
    RX = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_cyc(BD);
      RX = d[i];
    end
    wait_cyc(BD / 2);
    #2 rst = 1'b1;
    #1;
    checks++; if (pwr_up !== 1'b0) begin failures++; $display("FAIL t6_async_pwr got=%b exp=0", pwr_up); end
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL t6_async_data got=%h exp=00", rx_data); end
    checks++; if (rx_rdy !== 1'b0 || frm_err !== 1'b0) begin failures++; $display("FAIL t6_async_pulses got=%b%b exp=00", rx_rdy, frm_err); end
    RX = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    n0 = rdy_cnt;
    wait_cyc(12 * BD);
    checks++; if (rdy_cnt != n0 || pwr_up !== 1'b0) begin failures++; $display("FAIL t6_no_partial got=%0d/%b exp=%0d/0", rdy_cnt, pwr_up, n0); end
    send_byte(8'h47, 1'b1);
    wait_cyc(2);
    checks++; if (pwr_up !== 1'b1 || rx_data !== 8'h47) begin failures++; $display("FAIL t6_clean_g got=%b/%h exp=1/47", pwr_up, rx_data); end
    checks++; if (rdy_cnt != n0 + 1) begin failures++; $display("FAIL t6_rdy_count got=%0d exp=%0d", rdy_cnt, n0 + 1); end
  endtask

  initial begin
    test_reset();
    test_power_stop();
    test_stop_rider_off();
    test_foreign_framing();
    test_link_timeout();
    test_back_to_back();
    test_reset_midframe();
    checks++; if (both_cnt != 0) begin failures++; $display("FAIL pulse_overlap got=%0d exp=0", both_cnt); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmd_auth.md
# cmd_auth

Receives 8N1 serial commands from the Bluetooth module on the Segway's RX pin and decides whether the platform is powered. It decodes the power-up ('G', 8'h47) and stop ('S', 8'h53) bytes. It also watches the rider-present status from the steering/load-cell path. It drives `pwr_up`, which enables the balance controller and motor drive downstream.

## Interface
- `BAUD_DIV`, default 5208: clk cycles per bit (50 MHz / 9600 baud); legal range 16..65535.
- `LINK_TO`, default 25_000_000: idle cycles in PWR1 before a lost link is treated as 'S' (0.5 s). 0 disables the timeout.
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  asynchronous, active-high reset.
- `RX`  in  1  async serial input; idle high.
- `rider_off`  in  1  high when the rider is off the platform (synchronous, from steering block).
- `pwr_up`  out  1  platform enable; registered.
- `rx_data`  out  8  last good received byte; registered.
- `rx_rdy`  out  1  one-cycle pulse when `rx_data` updates.
- `frm_err`  out  1  one-cycle pulse when a byte is discarded for a bad stop bit.

## Operation
- **Reset values:** `pwr_up`=0, `rx_data`=8'h00, `rx_rdy`=0, `frm_err`=0, receiver IDLE, auth state OFF, timeout counter 0.
- **RX synchronizer:** two flops, preset to 1 by reset.
- **Receiver states:**
  - IDLE: waits for synchronized RX=0.
  - START: counts BAUD_DIV/2 cycles. At that point:
    - if RX is still 0, go to DATA;
    - if RX is 1 (glitch), return to IDLE.
  - DATA: samples 8 bits, one every BAUD_DIV cycles, shifting LSB-first.
  - STOP: samples once more after BAUD_DIV cycles.
    - Stop bit = 1: load `rx_data` and pulse `rx_rdy`.
    - Stop bit = 0: pulse `frm_err`, leave `rx_data` unchanged, and wait for RX=1 before re-entering IDLE.
- **Auth FSM:** acts only on `rx_rdy` pulses; any byte other than 'G'/'S' is ignored.
  - OFF: 'G' → PWR1.
  - PWR1:
    - 'S' with `rider_off`=1 → OFF;
    - 'S' with `rider_off`=0 → PWR2;
    - timeout expiry → treated as 'S';
    - 'G' → stay in PWR1 and restart the timeout.
  - PWR2:
    - 'G' → PWR1;
    - `rider_off`=1 → OFF (checked every cycle).
- **`pwr_up` output:** `pwr_up`=1 in PWR1 and PWR2, 0 in OFF.
- **Link timeout counter:**
  - 25 bits, saturating.
  - Clears on every `rx_rdy` and whenever the state is not PWR1.
  - Expires when it reaches LINK_TO-1.
- **Simultaneous events in PWR2:** if a 'G' `rx_rdy` arrives in the same cycle as `rider_off`=1, 'G' wins → PWR1.

## Timing
- **Sampling point:** data bit n is sampled at BAUD_DIV/2 + (n+1)·BAUD_DIV cycles after the synchronized falling edge.
- **`rx_rdy` timing:** `rx_rdy` asserts at BAUD_DIV/2 + 9·BAUD_DIV cycles after the synchronized falling edge. That is +2 cycles relative to the raw RX edge.
- **Output latency:** `pwr_up` changes on the clock edge after `rx_rdy`, i.e. 1 cycle latency. FSM transitions are registered.
- **Back-to-back bytes:** accepted with no idle gap. The receiver returns to IDLE at the stop-bit sample, so the next start edge is caught.
- **Reset mid-frame:** reset aborts the frame; the partial byte is lost with no `rx_rdy`. After release, RX is low mid-frame, so the receiver resynchronizes: it may mis-frame until a stop bit fails, then recovers on the next idle.
- **Pulse width:** `rx_rdy` and `frm_err` are exactly 1 cycle and never both high.

## Structure
- **Package `seg_pkg`:**
  - `typedef enum logic [1:0] {OFF, PWR1, PWR2} auth_state_t`;
  - receiver state enum;
  - `CMD_GO`=8'h47, `CMD_STOP`=8'h53.
- **Sub-module `uart_rx`:** parameter BAUD_DIV; ports clk, rst, RX, rx_data, rx_rdy, frm_err.
- **Top level:** `cmd_auth` holds the auth FSM and the timeout counter.

## Test plan
All scenarios use BAUD_DIV=32, LINK_TO=4000, and a `UART_tx` at matching baud as the source.

1. **Power up / stop, rider present:** send 8'h47 → `rx_rdy` with `rx_data`=8'h47, `pwr_up`=1 one cycle later. Send 8'h53 with `rider_off`=0 → `pwr_up` stays 1 (PWR2). Raise `rider_off` → `pwr_up`=0 next cycle.
2. **Stop with rider already off:** send 'G', then 'S' with `rider_off`=1 → `pwr_up`=0 one cycle after the second `rx_rdy`.
3. **Foreign bytes and framing:**
   - 8'h41 and 8'hFF in OFF → `rx_rdy` pulses, `pwr_up` stays 0.
   - A frame with stop bit 0 → `frm_err` pulse, no `rx_rdy`, `rx_data` unchanged.
   - 0.3-bit start glitch → no pulses.
4. **Link timeout:** send 'G', then hold RX high with `rider_off`=0. After 4000 cycles the FSM enters PWR2 and `pwr_up` stays 1. Then raise `rider_off` → `pwr_up`=0. Re-sending 'G' every 3000 cycles must keep PWR1 indefinitely.
5. **Back-to-back traffic:** 'G','S','G' with no gaps → three `rx_rdy` pulses, 32·10 cycles apart; final state PWR1.
6. **Reset:** assert `rst` at bit 4 of a 'G' frame → all outputs at reset values immediately (asynchronous). A subsequent clean 'G' → `pwr_up`=1.
